// File: rtl/display_palette.sv
// Category-to-RGB mapper: runtime-writable palette, per-category blinking, video blanking, 2-cycle pipeline.
// Optional hit-flash colour inversion is enabled by defining DISPLAY_PALETTE_HIT_FLASH_EN.
module display_palette #(
    parameter int CAT_W        = 4,
    parameter int NUM_CAT      = 16,
    parameter int COLOR_W      = 4,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CAT_W-1:0]       category,
    input  logic                   video_on,
    input  logic                   frame_tick,
    input  logic [NUM_CAT-1:0]     blink_mask,
    input  logic                   pal_we,
    input  logic [CAT_W-1:0]       pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_data,
`ifdef DISPLAY_PALETTE_HIT_FLASH_EN
    input  logic                   hit_flash,
`endif
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   blink_phase
);

    localparam int RGB_W = 3 * COLOR_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [COLOR_W-1:0] CH_ONES  = '1;
    localparam logic [COLOR_W-1:0] CH_ZERO  = '0;

    function automatic logic [RGB_W-1:0] default_entry(input int idx);
        case (idx)
            1, 2:    return {CH_ONES, CH_ONES, CH_ONES};
            3:       return {CH_ZERO, CH_ONES, CH_ONES};
            default: return '0;
        endcase
    endfunction

    logic [RGB_W-1:0] palette [NUM_CAT];
    logic [RGB_W-1:0] lookup_entry;
    logic             lookup_mask;
    logic [RGB_W-1:0] entry_s1;
    logic             video_on_s1;
    logic             hide_s1;
    logic [RGB_W-1:0] visible;
    logic [RGB_W-1:0] rgb_next;
    logic [RGB_W-1:0] rgb_q;
    logic [CNT_W-1:0] blink_cnt;
    logic             flash_active;

    // Addresses at or above NUM_CAT never match an entry, so such writes fall away.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CAT; i++) begin
            if (rst) begin
                palette[i] <= default_entry(i);
            end else if (pal_we && pal_addr == CAT_W'(i)) begin
                palette[i] <= pal_data;
            end
        end
    end

    // Out-of-range categories leave the defaults: black entry, never hidden.
    always_comb begin
        lookup_entry = '0;
        lookup_mask  = 1'b0;
        for (int i = 0; i < NUM_CAT; i++) begin
            if (category == CAT_W'(i)) begin
                lookup_entry = palette[i];
                lookup_mask  = blink_mask[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef DISPLAY_PALETTE_HIT_FLASH_EN
    logic [2:0] flash_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cnt <= '0;
        end else if (hit_flash) begin
            flash_cnt <= 3'd4;
        end else if (frame_tick && flash_cnt != 3'd0) begin
            flash_cnt <= flash_cnt - 3'd1;
        end
    end

    assign flash_active = (flash_cnt != 3'd0);
`else
    assign flash_active = 1'b0;
`endif

    // Stage 1 uses the pre-tick blink_phase, since the register updates on this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_s1    <= '0;
            video_on_s1 <= 1'b0;
            hide_s1     <= 1'b0;
        end else begin
            entry_s1    <= lookup_entry;
            video_on_s1 <= video_on;
            hide_s1     <= blink_phase & lookup_mask;
        end
    end

    always_comb begin
        visible  = hide_s1 ? '0 : entry_s1;
        rgb_next = '0;
        if (video_on_s1) begin
            rgb_next = flash_active ? ~visible : visible;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_next;
        end
    end

    assign red   = rgb_q[RGB_W-1 -: COLOR_W];
    assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_display_palette.sv
// Bench for display_palette: directed literal checks plus randomized traffic against a palette/blink model.
module tb_display_palette;
    localparam int CAT_W        = 5;
    localparam int NUM_CAT      = 16;
    localparam int COLOR_W      = 4;
    localparam int BLINK_FRAMES = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic [CAT_W-1:0]     category = '0;
    logic                 video_on = 1'b0;
    logic                 frame_tick = 1'b0;
    logic [NUM_CAT-1:0]   blink_mask = '0;
    logic                 pal_we = 1'b0;
    logic [CAT_W-1:0]     pal_addr = '0;
    logic [3*COLOR_W-1:0] pal_data = '0;
    logic                 hit_flash = 1'b0;
    logic [COLOR_W-1:0]   red, green, blue;
    logic                 blink_phase;

    display_palette #(
        .CAT_W(CAT_W), .NUM_CAT(NUM_CAT), .COLOR_W(COLOR_W), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .category(category), .video_on(video_on),
        .frame_tick(frame_tick), .blink_mask(blink_mask), .pal_we(pal_we),
        .pal_addr(pal_addr), .pal_data(pal_data),
`ifdef DISPLAY_PALETTE_HIT_FLASH_EN
        .hit_flash(hit_flash),
`endif
        .red(red), .green(green), .blue(blue), .blink_phase(blink_phase)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %03h expected %03h at %0t", name, got, exp, $time);
    endtask

    // behavioural model: palette contents, blink phase, expected output stream
    logic [11:0] exp_q[$];
    logic [11:0] m_pal[NUM_CAT];
    bit          m_phase = 1'b0;
    int          m_cnt   = 0;
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin : model
        logic [11:0] px;
        int          idx;
        if (rst) begin
            for (int i = 0; i < NUM_CAT; i++)
                m_pal[i] = (i == 1 || i == 2) ? 12'hFFF : (i == 3) ? 12'h0FF : 12'h000;
            m_phase = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
            exp_q.push_back(12'h000);
            exp_q.push_back(12'h000);
            chk_en = 1'b1;
        end else begin
            idx = int'(category);
            px  = 12'h000;
            if (idx < NUM_CAT && video_on) begin
                if (!(m_phase && blink_mask[idx])) px = m_pal[idx];
            end
            exp_q.push_back(px);
            if (pal_we && int'(pal_addr) < NUM_CAT) m_pal[int'(pal_addr)] = pal_data;
            if (frame_tick) begin
                if (m_cnt == BLINK_FRAMES - 1) begin
                    m_cnt   = 0;
                    m_phase = !m_phase;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // scoreboard compare, every cycle once reset has been seen
    always @(negedge clk) begin : compare
        logic [11:0] e;
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 12'h001, 12'h000);
            end else begin
                e = exp_q.pop_front();
                check("rgb", {red, green, blue}, e);
            end
            check("blink_phase", {11'b0, blink_phase}, {11'b0, m_phase});
        end
    end

    // driver
    task automatic step(input logic [CAT_W-1:0] c, input logic v, input logic t = 1'b0,
                        input logic we = 1'b0, input logic [CAT_W-1:0] a = '0,
                        input logic [11:0] d = 12'h000, input logic r = 1'b0);
        @(negedge clk);
        category   = c;
        video_on   = v;
        frame_tick = t;
        pal_we     = we;
        pal_addr   = a;
        pal_data   = d;
        rst        = r;
    endtask

    task automatic lit(input string name, input logic [11:0] exp);
        check(name, {red, green, blue}, exp);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 1);
        // basic lookups
        step(3, 1); step(1, 1); step(0, 1); lit("cat3", 12'h0FF);
        step(9, 1); lit("cat1", 12'hFFF);
        step(0, 0); lit("cat0", 12'h000);
        step(1, 0); lit("cat9", 12'h000);
        step(1, 0);
        step(0, 0); lit("video_off_cat1", 12'h000);
        // video drop mid-stream
        step(1, 1); step(1, 1); step(1, 0);
        step(1, 0); lit("before_drop", 12'hFFF);
        step(1, 0); lit("after_drop", 12'h000);
        // write and lookup of the same entry in one cycle
        step(2, 1, 0, 1, 2, 12'hF00); step(2, 1);
        step(0, 0); lit("write_old", 12'hFFF);
        step(0, 0); lit("write_new", 12'hF00);
        // out-of-range address and category
        step(0, 1, 0, 1, 16, 12'hABC); step(0, 1);
        step(0, 0); step(0, 0); lit("bad_addr_ignored", 12'h000);
        step(20, 1); step(0, 0); step(0, 0); lit("cat_oob", 12'h000);
        // reset during streaming
        step(1, 1); step(1, 1); step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1); lit("rst_black", 12'h000);
        step(1, 1); lit("rst_flush", 12'h000);
        step(2, 1); step(0, 0);
        step(0, 0); lit("rst_pal_default", 12'hFFF);
        // blinking on category 3
        blink_mask = 16'h0008;
        step(3, 1, 1); step(3, 1); step(3, 1, 1);
        step(3, 1); check("phase_after_2", {11'b0, blink_phase}, 12'h001);
        step(3, 1); lit("pre_tick_pixel", 12'h0FF);
        step(3, 1); lit("blink_hidden", 12'h000);
        step(1, 1); step(1, 1);
        step(3, 1); lit("cat1_unmasked", 12'hFFF);
        step(3, 1, 1); step(3, 1, 1);
        step(3, 1); check("phase_after_4", {11'b0, blink_phase}, 12'h000);
        step(3, 1);
        step(3, 1); lit("blink_return", 12'h0FF);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) blink_mask = NUM_CAT'($urandom);
            step(CAT_W'($urandom_range(0, 19)), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 CAT_W'($urandom_range(0, 19)), 12'($urandom),
                 $urandom_range(0, 299) == 0);
        end
        step(0, 0); step(0, 0); step(0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
